// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, owner tags, fetch mask.
// Optional feature macro RR_ARB_EN selects round-robin arbitration.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        LS_BUSY = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [3:0] FETCH_MASK = 4'b1111;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational grant selection between fetch and load/store requesters.
// RR_ARB_EN: ties go to the requester not served last; else load/store wins.
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic   i_if_req,
    input  logic   i_ls_req,
`ifdef RR_ARB_EN
    input  owner_t i_last,
`endif
    output logic   o_grant,
    output owner_t o_owner
);

    // Pick the winner; a lone requester always wins
    always_comb begin
        o_grant = i_if_req | i_ls_req;
        o_owner = OWN_LS;
        if (i_if_req && i_ls_req) begin
`ifdef RR_ARB_EN
            o_owner = (i_last == OWN_LS) ? OWN_IF : OWN_LS;
`else
            o_owner = OWN_LS;
`endif
        end else if (i_if_req) begin
            o_owner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-client arbiter (fetch, load/store) onto one memory port, one txn in flight.
// RR_ARB_EN: round-robin on ties; default build is fixed load/store priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [DataWidth-1:0] if_addr,
    output logic                 if_valid,
    output logic [DataWidth-1:0] if_rdata,
    input  logic                 ls_req,
    input  logic                 ls_we_re,
    input  logic [3:0]           ls_mask,
    input  logic [DataWidth-1:0] ls_addr,
    input  logic [DataWidth-1:0] ls_wdata,
    output logic                 ls_valid,
    output logic [DataWidth-1:0] ls_rdata,
    output logic                 mem_req,
    output logic                 mem_we_re,
    output logic [3:0]           mem_mask,
    output logic [DataWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic                 mem_valid,
    input  logic [DataWidth-1:0] mem_rdata
);

    state_t               r_state;
    state_t               w_next;
    logic                 w_grant;
    owner_t               w_owner;
    logic                 w_take;
    logic [DataWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;
    logic [3:0]           r_mask;
    logic                 r_we;
    logic                 r_if_valid;
    logic                 r_ls_valid;
    logic [DataWidth-1:0] r_if_rdata;
    logic [DataWidth-1:0] r_ls_rdata;

    assign w_take = (r_state == IDLE) && w_grant;

`ifdef RR_ARB_EN
    owner_t r_last;

    // Remember who was granted last; fetch so the first tie goes to load/store
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_last <= OWN_IF;
        else if (w_take) r_last <= w_owner;
    end
`endif

    mem_arb_select u_sel (
        .i_if_req (if_req),
        .i_ls_req (ls_req),
`ifdef RR_ARB_EN
        .i_last   (r_last),
`endif
        .o_grant  (w_grant),
        .o_owner  (w_owner)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next state: grant from IDLE, return to IDLE on memory completion
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant)
                    w_next = (w_owner == OWN_LS) ? LS_BUSY : IF_BUSY;
            end
            IF_BUSY, LS_BUSY: begin
                if (mem_valid) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture the winner's request fields so memory sees them stable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_we    <= 1'b0;
        end else if (w_take) begin
            if (w_owner == OWN_LS) begin
                r_addr  <= ls_addr;
                r_wdata <= ls_wdata;
                r_mask  <= ls_mask;
                r_we    <= ls_we_re;
            end else begin
                r_addr  <= if_addr;
                r_wdata <= '0;
                r_mask  <= FETCH_MASK;
                r_we    <= 1'b0;
            end
        end
    end

    // Route completion to the owner: one-cycle valid, rdata held until next
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_valid <= 1'b0;
            r_ls_valid <= 1'b0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
        end else begin
            r_if_valid <= (r_state == IF_BUSY) && mem_valid;
            r_ls_valid <= (r_state == LS_BUSY) && mem_valid;
            if ((r_state == IF_BUSY) && mem_valid) r_if_rdata <= mem_rdata;
            if ((r_state == LS_BUSY) && mem_valid) r_ls_rdata <= mem_rdata;
        end
    end

    // Outputs: memory request while busy, fields from the capture registers
    always_comb begin
        mem_req   = (r_state != IDLE);
        mem_we_re = r_we;
        mem_mask  = r_mask;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if_valid  = r_if_valid;
        if_rdata  = r_if_rdata;
        ls_valid  = r_ls_valid;
        ls_rdata  = r_ls_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a stallable memory model.
// Tie expectations follow RR_ARB_EN when the build defines it.
module tb_mem_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we_re;
    logic [3:0]    ls_mask;
    logic [DW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_valid;
    logic [DW-1:0] ls_rdata;
    logic          mem_req;
    logic          mem_we_re;
    logic [3:0]    mem_mask;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_valid;
    logic [DW-1:0] mem_rdata;

    int   n_cmp = 0;
    int   n_err = 0;
    int   stall = 0;
    int   wcnt  = 0;
    logic force_v = 1'b0;

    always #5 clk = ~clk;

    // Memory model: completes after 'stall' wait cycles, or when forced
    assign mem_valid = force_v | (mem_req && (wcnt >= stall));

    always @(posedge clk) begin
        if (!mem_req || mem_valid) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    mem_arbiter #(.DataWidth(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we_re  (ls_we_re),
        .ls_mask   (ls_mask),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_valid  (ls_valid),
        .ls_rdata  (ls_rdata),
        .mem_req   (mem_req),
        .mem_we_re (mem_we_re),
        .mem_mask  (mem_mask),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_own [4];

    initial begin
`ifdef RR_ARB_EN
        exp_own = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_own = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        rst = 1'b0;
        if_req = 0; if_addr = '0;
        ls_req = 0; ls_we_re = 0; ls_mask = '0; ls_addr = '0; ls_wdata = '0;
        mem_rdata = '0;
        repeat (3) step();
        chk("rst_mem_req", DW'(mem_req), 0);
        chk("rst_if_valid", DW'(if_valid), 0);
        chk("rst_ls_valid", DW'(ls_valid), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_rdata", if_rdata, 0);
        rst = 1'b1;
        step();

        // Zero-wait fetch
        stall = 0;
        if_req = 1; if_addr = 32'h100; mem_rdata = 32'h13;
        step();
        chk("f_mem_req", DW'(mem_req), 1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", DW'(mem_we_re), 0);
        chk("f_mem_mask", DW'(mem_mask), 32'hF);
        chk("f_valid_n1", DW'(if_valid), 0);
        step();
        chk("f_if_valid", DW'(if_valid), 1);
        chk("f_if_rdata", if_rdata, 32'h13);
        chk("f_ls_valid", DW'(ls_valid), 0);
        if_req = 0;
        step();
        chk("f_pulse_end", DW'(if_valid), 0);
        chk("f_idle", DW'(mem_req), 0);
        chk("f_rdata_hold", if_rdata, 32'h13);

        // Byte-masked store
        ls_req = 1; ls_we_re = 1; ls_mask = 4'b0011;
        ls_addr = 32'h2000; ls_wdata = 32'hBEEF; mem_rdata = 32'hDEAD;
        step();
        chk("s_mem_we", DW'(mem_we_re), 1);
        chk("s_mem_mask", DW'(mem_mask), 32'h3);
        chk("s_mem_wdata", mem_wdata, 32'hBEEF);
        chk("s_mem_addr", mem_addr, 32'h2000);
        chk("s_valid_n1", DW'(ls_valid), 0);
        step();
        chk("s_ls_valid", DW'(ls_valid), 1);
        chk("s_if_valid", DW'(if_valid), 0);
        ls_req = 0;
        step();
        chk("s_pulse_end", DW'(ls_valid), 0);

        // Reset then contention with both requests held
        rst = 1'b0;
        step();
        rst = 1'b1;
        if_req = 1; if_addr = 32'h100;
        ls_req = 1; ls_we_re = 0; ls_mask = 4'hF; ls_addr = 32'h200;
        mem_rdata = 32'h77;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("tie_addr%0d", i), mem_addr,
                exp_own[i][0] ? 32'h200 : 32'h100);
            step();
            chk($sformatf("tie_valid%0d", i), DW'({if_valid, ls_valid}),
                DW'(exp_own[i]));
        end
        if_req = 0; ls_req = 0;
        step();
        chk("tie_idle", DW'(mem_req), 0);

        // Stalled fetch, request dropped mid-transaction
        stall = 5;
        if_req = 1; if_addr = 32'h340; mem_rdata = 32'h55;
        step();
        if_req = 0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("st_req%0d", i), DW'(mem_req), 1);
            chk($sformatf("st_addr%0d", i), mem_addr, 32'h340);
            chk($sformatf("st_valid%0d", i), DW'(if_valid), 0);
            step();
        end
        chk("st_mem_valid", DW'(mem_valid), 1);
        chk("st_req_last", DW'(mem_req), 1);
        step();
        chk("st_if_valid", DW'(if_valid), 1);
        chk("st_if_rdata", if_rdata, 32'h55);
        step();
        chk("st_single", DW'(if_valid), 0);

        // Stray memory completion while idle
        force_v = 1;
        step();
        force_v = 0;
        chk("stray_if", DW'(if_valid), 0);
        chk("stray_ls", DW'(ls_valid), 0);
        step();
        chk("stray_if2", DW'(if_valid), 0);
        chk("stray_ls2", DW'(ls_valid), 0);
        chk("stray_req", DW'(mem_req), 0);

        // Reset during a load/store transaction
        ls_req = 1; ls_we_re = 0; ls_mask = 4'hF; ls_addr = 32'h44;
        step();
        chk("r_busy", DW'(mem_req), 1);
        rst = 1'b0;
        #1;
        chk("r_req_async", DW'(mem_req), 0);
        chk("r_addr_async", mem_addr, 0);
        ls_req = 0;
        force_v = 1;
        step();
        force_v = 0;
        chk("r_ls_valid0", DW'(ls_valid), 0);
        rst = 1'b1;
        step();
        chk("r_ls_valid1", DW'(ls_valid), 0);
        step();
        chk("r_ls_valid2", DW'(ls_valid), 0);
        chk("r_ls_rdata", ls_rdata, 0);
        chk("r_mem_mask", DW'(mem_mask), 0);
        chk("r_mem_wdata", mem_wdata, 0);
        chk("r_mem_we", DW'(mem_we_re), 0);
        chk("r_mem_req", DW'(mem_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
